// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: clocked instruction store for the IF stage.
// A request's memory read happens on the accept edge and then travels through
// LATENCY-1 further stages. The last stage is the response seen by decode.
// When decode stalls, finished fetches wait in an in-order queue.
// The block also provides flush, alignment/range fault reporting and a
// program-load write port.
module instr_fetch_mem #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter int                LATENCY   = 1,
  parameter                    INIT_FILE = "instr.mem",
  parameter logic [DATA_W-1:0] NOP       = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [1:0]        rsp_err,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int QD    = LATENCY + 1;
  localparam int PTR_W = $clog2(QD);
  localparam int CNT_W = $clog2(QD + 1);

  // Fault bits for a byte address: bit0 misaligned, bit1 beyond the array.
  function automatic logic [1:0] addr_fault(input logic [ADDR_W-1:0] a);
    logic [1:0] f;
    f[0] = |a[1:0];
    f[1] = |a[ADDR_W-1:IDX_W+2];
    return f;
  endfunction

  // Queue pointer advance, wrapping modulo the queue depth.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QD - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic [LATENCY-1:0] st_valid;
  logic [ADDR_W-1:0]  st_addr [LATENCY];
  logic [1:0]         st_err  [LATENCY];
  logic [DATA_W-1:0]  st_data [LATENCY];

  logic [ADDR_W-1:0]  q_addr [QD];
  logic [1:0]         q_err  [QD];
  logic [DATA_W-1:0]  q_data [QD];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   q_count, occ;

  logic [IDX_W-1:0]   req_idx, load_idx;
  logic [1:0]         req_fault;
  logic               load_ok, q_empty, consume, accept, push, pop;

  // Address decode, response selection, handshake and queue control.
  always_comb begin
    req_idx   = req_addr[IDX_W+1:2];
    req_fault = addr_fault(req_addr);
    load_idx  = load_addr[IDX_W+1:2];
    load_ok   = load_we && (addr_fault(load_addr) == 2'b00);
    q_empty   = (q_count == CNT_W'(0));
    rsp_valid = !q_empty || st_valid[LATENCY-1];
    if (!q_empty) begin
      rsp_instr = q_data[rd_ptr];
      rsp_addr  = q_addr[rd_ptr];
      rsp_err   = q_err[rd_ptr];
    end else if (st_valid[LATENCY-1]) begin
      rsp_instr = st_data[LATENCY-1];
      rsp_addr  = st_addr[LATENCY-1];
      rsp_err   = st_err[LATENCY-1];
    end else begin
      rsp_instr = NOP;
      rsp_addr  = '0;
      rsp_err   = 2'b00;
    end
    consume   = rsp_valid && rsp_ready;
    req_ready = !flush && ((occ < CNT_W'(QD)) || ((occ == CNT_W'(QD)) && consume));
    accept    = req_valid && req_ready;
    pop       = consume && !q_empty;
    // The last stage parks in the queue unless it is handed straight to decode.
    push      = st_valid[LATENCY-1] && !(q_empty && consume);
  end

  // Program-load writes. The array has no reset.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[load_idx] <= load_data;
    end
  end

  // Read pipeline, queue pointers and occupancy. Flush and reset empty everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        st_addr[i] <= '0;
        st_err[i]  <= 2'b00;
        st_data[i] <= NOP;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
      occ     <= '0;
    end else if (flush) begin
      st_valid <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      q_count  <= '0;
      occ      <= '0;
    end else begin
      st_valid[0] <= accept;
      st_addr[0]  <= req_addr;
      st_err[0]   <= req_fault;
      if (accept) begin
        // A faulting fetch never touches the array. The read sees the old word
        // if a load writes the same location on this edge.
        st_data[0] <= (req_fault != 2'b00) ? NOP : mem[req_idx];
      end
      for (int i = 1; i < LATENCY; i++) begin
        st_valid[i] <= st_valid[i-1];
        st_addr[i]  <= st_addr[i-1];
        st_err[i]   <= st_err[i-1];
        st_data[i]  <= st_data[i-1];
      end
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      q_count <= q_count + CNT_W'(push) - CNT_W'(pop);
      occ     <= occ + CNT_W'(accept) - CNT_W'(consume);
    end
  end

  // Queue storage. Only the pointers and the count need a reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= st_addr[LATENCY-1];
      q_err[wr_ptr]  <= st_err[LATENCY-1];
      q_data[wr_ptr] <= st_data[LATENCY-1];
    end
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb_instr_fetch_mem: scoreboard bench for instr_fetch_mem (LATENCY=3, DEPTH=1024).
// The driver predicts each accepted fetch from a word-array model of memory and
// queues it. The monitor independently checks every visible response against
// the queue head.
module tb_instr_fetch_mem;

  localparam int LAT = 3;
  localparam int QD  = LAT + 1;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, flush = 1'b0, rsp_ready = 1'b0, load_we = 1'b0;
  logic [31:0] req_addr = 32'd0, load_addr = 32'd0, load_data = 32'd0;
  logic        req_ready, rsp_valid;
  logic [31:0] rsp_instr, rsp_addr;
  logic [1:0]  rsp_err;

  instr_fetch_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [1:0]  err;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [1024];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          dut_acc = 0;

  // Cycle counter used to time when each fetch should become visible.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected response for a fetch, derived from the address rules and the model array.
  function automatic exp_t model_fetch(input logic [31:0] a);
    exp_t e;
    e.addr   = a;
    e.err[0] = (a[1:0] != 2'b00);
    e.err[1] = ((a >> 2) >= 32'd1024);
    e.instr  = (e.err != 2'b00) ? NOP : model_mem[a[11:2]];
    e.acc    = cyc;
    return e;
  endfunction

  function automatic logic head_visible();
    return (sb.size() > 0) && (cyc >= sb[0].acc + LAT);
  endfunction

  // One clock of stimulus. Predicts req_ready and acceptance, and updates the model.
  task automatic drive_cycle(input logic rv, input logic [31:0] a, input logic rr,
                             input logic fl, input logic we, input logic [31:0] la,
                             input logic [31:0] ld);
    logic exp_ready;
    int   occ;
    @(negedge clk);
    req_valid = rv; req_addr = a; rsp_ready = rr; flush = fl;
    load_we = we; load_addr = la; load_data = ld;
    #3;
    occ       = sb.size();
    exp_ready = !fl && ((occ < QD) || ((occ == QD) && head_visible() && rr));
    check("req_ready", {63'd0, req_ready}, {63'd0, exp_ready});
    if (rv && req_ready) dut_acc++;
    if (rv && exp_ready) sb.push_back(model_fetch(a));
    if (we && (la[1:0] == 2'b00) && ((la >> 2) < 32'd1024)) model_mem[la[11:2]] = ld;
    @(posedge clk);
    #1;
    if (fl) sb.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) idle(1);
    check("drain_outstanding", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every cycle, compare the visible response with the scoreboard head.
  initial begin
    exp_t h;
    logic exp_v;
    forever begin
      @(negedge clk);
      #4;
      exp_v = head_visible();
      check("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_v});
      if (exp_v && rsp_valid) begin
        h = sb[0];
        check("rsp_instr", {32'd0, rsp_instr}, {32'd0, h.instr});
        check("rsp_addr", {32'd0, rsp_addr}, {32'd0, h.addr});
        check("rsp_err", {62'd0, rsp_err}, {62'd0, h.err});
        if (rsp_ready) void'(sb.pop_front());
      end
    end
  end

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded 1000000 ns, expected to finish");
    $fatal(1, "timeout");
  end

  // Main stimulus sequence.
  initial begin
    logic [31:0] image [4];
    logic [31:0] a, la;
    image[0] = 32'h00500093; image[1] = 32'h00100113;
    image[2] = 32'h002081B3; image[3] = 32'h00000013;

    #2;
    check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("reset_rsp_instr", {32'd0, rsp_instr}, {32'd0, NOP});
    check("reset_rsp_addr", {32'd0, rsp_addr}, 64'd0);
    check("reset_rsp_err", {62'd0, rsp_err}, 64'd0);
    check("reset_req_ready", {63'd0, req_ready}, 64'd1);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Program the whole array: image words first, random words above.
    for (int i = 0; i < 1024; i++)
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'(i * 4), (i < 4) ? image[i] : $urandom);

    // Back-to-back fetches of the image with decode always ready.
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    drain();

    // Backpressure: exactly LAT+1 fetches fit, then decode drains them in order.
    dut_acc = 0;
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 32'(dut_acc * 4), 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("full_accept_count", 64'(dut_acc), 64'(QD));
    drive_cycle(1'b1, 32'd16, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    drain();

    // Faults: misaligned, out of range, both.
    drive_cycle(1'b1, 32'h6, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_cycle(1'b1, 32'h1000, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_cycle(1'b1, 32'h1002, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    drain();

    // Flush with two fetches in flight and a request in the flush cycle.
    drive_cycle(1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_cycle(1'b1, 32'd4, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_cycle(1'b1, 32'd8, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
    drive_cycle(1'b1, 32'd8, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    drain();

    // Load and fetch of the same word in one cycle: old data, then new data.
    drive_cycle(1'b1, 32'd4, 1'b1, 1'b0, 1'b1, 32'd4, 32'hDEADBEEF);
    drive_cycle(1'b1, 32'd4, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    drain();

    // Reset while three fetches are outstanding and a response is waiting.
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    #2;
    check("pre_reset_valid", {63'd0, rsp_valid}, 64'd1);
    reset = 1'b1;
    sb.delete();
    #1;
    check("async_reset_valid", {63'd0, rsp_valid}, 64'd0);
    check("async_reset_instr", {32'd0, rsp_instr}, {32'd0, NOP});
    check("async_reset_addr", {32'd0, rsp_addr}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(6);
    drive_cycle(1'b1, 32'd8, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    drain();

    // Randomized traffic with backpressure, flushes, loads and faults.
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 15))
        0:       a = $urandom;
        1:       a = {20'd0, 10'($urandom), 2'($urandom_range(1, 3))};
        default: a = {20'd0, 10'($urandom), 2'b00};
      endcase
      la = ($urandom_range(0, 3) == 0) ? a : {20'd0, 10'($urandom), 2'b00};
      if ($urandom_range(0, 7) == 0) la = la | 32'd2;
      drive_cycle(($urandom_range(0, 3) != 0), a, ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0), la, $urandom);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
